// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: GPR index/data, FIFO entry, partial-register merge.
package wb_pkg;

  localparam int unsigned NREGS = 16;
  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned XLEN  = 64;

  typedef logic [IDX_W-1:0] gpr_idx_t;
  typedef logic [XLEN-1:0]  gpr_data_t;

  typedef enum logic [1:0] {
    SZ8  = 2'd0,
    SZ16 = 2'd1,
    SZ32 = 2'd2,
    SZ64 = 2'd3
  } wb_size_t;

  typedef struct packed {
    gpr_data_t result;
    gpr_idx_t  dest;
    wb_size_t  size;
    logic      high8;
    logic      wen;
  } wb_entry_t;

  // x86-64 write semantics: 8/16-bit writes keep the rest, 32-bit writes zero-extend.
  function automatic gpr_data_t wb_merge(input gpr_data_t old_val, input wb_entry_t e);
    gpr_data_t v;
    v = old_val;
    case (e.size)
      SZ8: begin
        if (e.high8) v[15:8] = e.result[7:0];
        else         v[7:0]  = e.result[7:0];
      end
      SZ16:    v[15:0] = e.result[15:0];
      SZ32:    v = {32'b0, e.result[31:0]};
      default: v = e.result;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Execute-to-writeback result handshake.
interface wb_if;
  import wb_pkg::*;

  logic      in_valid;
  logic      in_ready;
  gpr_data_t in_result;
  gpr_idx_t  in_dest;
  wb_size_t  in_size;
  logic      in_high8;
  logic      in_wen;

  modport master (
    output in_valid, in_result, in_dest, in_size, in_high8, in_wen,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_result, in_dest, in_size, in_high8, in_wen,
    output in_ready
  );
endinterface

// File: rtl/wb_fifo.sv
// In-order result FIFO; DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Push is gated on the registered full flag, so a full FIFO never looks ahead to the pop.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: result FIFO, 16x64 GPR file with partial writes, read ports, retire counter.
// Optional same-cycle commit bypass on the read ports with `define WB_BYPASS_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  wb_if.slave       bus,
  input  gpr_idx_t  rd_idx_a,
  input  gpr_idx_t  rd_idx_b,
  output gpr_data_t rd_data_a,
  output gpr_data_t rd_data_b,
  output gpr_data_t retired,
  output logic      empty
);

  gpr_data_t regs_q [NREGS];
  gpr_data_t regs_d [NREGS];
  gpr_data_t retired_q, retired_d;
  wb_entry_t in_entry;
  wb_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      commit;
  logic      commit_wr;
  gpr_data_t merged;

  assign in_entry = '{result: bus.in_result, dest: bus.in_dest, size: bus.in_size,
                      high8: bus.in_high8, wen: bus.in_wen};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.in_valid),
    .push_data (in_entry),
    .pop       (commit),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.in_ready = !fifo_full;
  assign empty        = fifo_empty;

  // Head commits every non-empty cycle; the reset edge never commits.
  always_comb begin
    commit    = !fifo_empty;
    commit_wr = commit && head.wen && !reset;
    merged    = wb_merge(regs_q[head.dest], head);
    regs_d    = regs_q;
    if (commit_wr) regs_d[head.dest] = merged;
    retired_d = retired_q + XLEN'(commit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      retired_q <= '0;
    end else begin
      regs_q    <= regs_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_idx_a];
    rd_data_b = regs_q[rd_idx_b];
`ifdef WB_BYPASS_EN
    if (commit_wr && (head.dest == rd_idx_a)) rd_data_a = merged;
    if (commit_wr && (head.dest == rd_idx_b)) rd_data_b = merged;
`endif
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;
  import wb_pkg::*;

  logic      clk;
  logic      reset;
  gpr_idx_t  rd_idx_a;
  gpr_idx_t  rd_idx_b;
  gpr_data_t rd_data_a;
  gpr_data_t rd_data_b;
  gpr_data_t retired;
  logic      empty;

  int        checks;
  int        errors;
  gpr_data_t exp_retired;

  wb_if bus ();

  writeback_stage #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .rd_idx_a  (rd_idx_a),
    .rd_idx_b  (rd_idx_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .retired   (retired),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input gpr_idx_t d, input wb_size_t s, input logic h, input logic w,
                       input gpr_data_t r);
    bus.in_dest   = d;
    bus.in_size   = s;
    bus.in_high8  = h;
    bus.in_wen    = w;
    bus.in_result = r;
    bus.in_valid  = 1'b1;
  endtask

  // One accepted entry on the next edge; it commits on the edge after.
  task automatic push(input gpr_idx_t d, input wb_size_t s, input logic h, input logic w,
                      input gpr_data_t r);
    drive(d, s, h, w, r);
    tick();
    bus.in_valid = 1'b0;
    exp_retired  = exp_retired + 64'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_retired = '0;
    for (int i = 0; i < 16; i++) begin
      rd_idx_a = gpr_idx_t'(i);
      #1;
      checks++;
      if (rd_data_a !== 64'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected %h", i, rd_data_a, 64'd0);
      end
    end
    checks++;
    if (retired !== 64'd0) begin
      errors++; $display("FAIL reset_retired: got %h expected 0", retired);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL reset_empty: got %b expected 1", empty);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_size32();
    push(4'd0, SZ64, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    push(4'd0, SZ32, 1'b0, 1'b1, 64'hDEAD_BEEF_1234_5678);
    tick();
    rd_idx_a = 4'd0;
    #1;
    checks++;
    if (rd_data_a !== 64'h0000_0000_1234_5678) begin
      errors++; $display("FAIL size32_zext: got %h expected %h", rd_data_a, 64'h0000_0000_1234_5678);
    end
    checks++;
    if (retired !== exp_retired) begin
      errors++; $display("FAIL size32_retired: got %0d expected %0d", retired, exp_retired);
    end
  endtask

  task automatic test_partial();
    rd_idx_a = 4'd3;
    push(4'd3, SZ64, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
    push(4'd3, SZ8, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFAB);
    tick();
    checks++;
    if (rd_data_a !== 64'h1111_2222_3333_AB44) begin
      errors++; $display("FAIL partial_high8: got %h expected %h", rd_data_a, 64'h1111_2222_3333_AB44);
    end
    push(4'd3, SZ16, 1'b1, 1'b1, 64'h7777_7777_7777_BEEF);
    tick();
    checks++;
    if (rd_data_a !== 64'h1111_2222_3333_BEEF) begin
      errors++; $display("FAIL partial_size16: got %h expected %h", rd_data_a, 64'h1111_2222_3333_BEEF);
    end
    push(4'd3, SZ8, 1'b0, 1'b1, 64'hAAAA_AAAA_AAAA_AA12);
    tick();
    checks++;
    if (rd_data_a !== 64'h1111_2222_3333_BE12) begin
      errors++; $display("FAIL partial_low8: got %h expected %h", rd_data_a, 64'h1111_2222_3333_BE12);
    end
    checks++;
    if (retired !== exp_retired) begin
      errors++; $display("FAIL partial_retired: got %0d expected %0d", retired, exp_retired);
    end
  endtask

  task automatic test_back_to_back();
    gpr_idx_t  dst [5];
    wb_size_t  sz  [5];
    logic      hi  [5];
    gpr_data_t dat [5];
    dst = '{4'd6, 4'd6, 4'd7, 4'd6, 4'd6};
    sz  = '{SZ64, SZ8, SZ64, SZ16, SZ8};
    hi  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dat = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h11, 64'h77, 64'h2222, 64'h33};
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        if (pass == 0) drive(dst[i], sz[i], hi[i], 1'b1, dat[i]);
        else           drive(dst[i], SZ64, 1'b0, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready p%0d c%0d: got %b expected 1", pass, i, bus.in_ready);
        end
        tick();
      end
      bus.in_valid = 1'b0;
      exp_retired  = exp_retired + 64'd5;
      tick();
      rd_idx_a = 4'd6;
      rd_idx_b = 4'd7;
      #1;
      checks++;
      if (rd_data_a !== 64'hAAAA_AAAA_AAAA_3322) begin
        errors++; $display("FAIL b2b_reg6 p%0d: got %h expected %h", pass, rd_data_a, 64'hAAAA_AAAA_AAAA_3322);
      end
      checks++;
      if (rd_data_b !== 64'h77) begin
        errors++; $display("FAIL b2b_reg7 p%0d: got %h expected %h", pass, rd_data_b, 64'h77);
      end
      checks++;
      if (retired !== exp_retired) begin
        errors++; $display("FAIL b2b_retired p%0d: got %0d expected %0d", pass, retired, exp_retired);
      end
      checks++;
      if (empty !== 1'b1) begin
        errors++; $display("FAIL b2b_empty p%0d: got %b expected 1", pass, empty);
      end
    end
  endtask

  task automatic test_reset_flush();
    drive(4'd11, SZ64, 1'b0, 1'b1, 64'h99);
    tick();
    checks++;
    if (empty !== 1'b0) begin
      errors++; $display("FAIL flush_buffered: got empty=%b expected 0", empty);
    end
    drive(4'd12, SZ64, 1'b0, 1'b1, 64'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    exp_retired  = '0;
    rd_idx_a = 4'd11;
    rd_idx_b = 4'd12;
    #1;
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL flush_empty: got %b expected 1", empty);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    checks++;
    if (rd_data_a !== 64'd0 || rd_data_b !== 64'd0) begin
      errors++; $display("FAIL flush_no_commit: got %h/%h expected 0/0", rd_data_a, rd_data_b);
    end
    checks++;
    if (retired !== 64'd0) begin
      errors++; $display("FAIL flush_retired: got %0d expected 0", retired);
    end
    push(4'd11, SZ64, 1'b0, 1'b1, 64'h99);
    tick();
    checks++;
    if (rd_data_a !== 64'h99) begin
      errors++; $display("FAIL flush_next_push: got %h expected %h", rd_data_a, 64'h99);
    end
    checks++;
    if (retired !== exp_retired) begin
      errors++; $display("FAIL flush_next_retired: got %0d expected %0d", retired, exp_retired);
    end
  endtask

  task automatic test_bypass();
    gpr_data_t exp_a;
    push(4'd5, SZ64, 1'b0, 1'b1, 64'h5555);
    tick();
    rd_idx_a = 4'd5;
    rd_idx_b = 4'd4;
    push(4'd5, SZ64, 1'b0, 1'b1, 64'h42);
    #1;
`ifdef WB_BYPASS_EN
    exp_a = 64'h42;
`else
    exp_a = 64'h5555;
`endif
    checks++;
    if (rd_data_a !== exp_a) begin
      errors++; $display("FAIL bypass_full_commit_cycle: got %h expected %h", rd_data_a, exp_a);
    end
    checks++;
    if (rd_data_b !== 64'd0) begin
      errors++; $display("FAIL bypass_other_port: got %h expected 0", rd_data_b);
    end
    tick();
    checks++;
    if (rd_data_a !== 64'h42) begin
      errors++; $display("FAIL bypass_full_after: got %h expected %h", rd_data_a, 64'h42);
    end
    push(4'd5, SZ8, 1'b1, 1'b1, 64'hEE);
    #1;
`ifdef WB_BYPASS_EN
    exp_a = 64'hEE42;
`else
    exp_a = 64'h42;
`endif
    checks++;
    if (rd_data_a !== exp_a) begin
      errors++; $display("FAIL bypass_partial_commit_cycle: got %h expected %h", rd_data_a, exp_a);
    end
    tick();
    checks++;
    if (rd_data_a !== 64'hEE42) begin
      errors++; $display("FAIL bypass_partial_after: got %h expected %h", rd_data_a, 64'hEE42);
    end
    push(4'd5, SZ64, 1'b0, 1'b0, 64'h1);
    #1;
    checks++;
    if (rd_data_a !== 64'hEE42) begin
      errors++; $display("FAIL bypass_nowen: got %h expected %h", rd_data_a, 64'hEE42);
    end
    tick();
    checks++;
    if (retired !== exp_retired) begin
      errors++; $display("FAIL bypass_retired: got %0d expected %0d", retired, exp_retired);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    exp_retired   = '0;
    reset         = 1'b1;
    rd_idx_a      = '0;
    rd_idx_b      = '0;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_dest   = '0;
    bus.in_size   = SZ8;
    bus.in_high8  = 1'b0;
    bus.in_wen    = 1'b0;
    test_reset();
    test_size32();
    test_partial();
    test_back_to_back();
    test_reset_flush();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
